sweep_seq: RTL and testbench

- Measurement sequencer for the bolometer front end.
- Steps the DAC output code across a programmable range. At each point it waits a settling time, triggers one ADC conversion, then streams the result as bytes to the UART transmitter.
- Sits between the top-level start control and the existing SPI DAC writer, SPI ADC reader and UART TX blocks. It only issues start pulses and waits for their completion pulses.

---
 rtl/sweep_seq_if.sv | 25 ++
 rtl/sweep_seq.sv | 165 ++++++++++++++++
 tb/tb_sweep_seq.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_seq_if.sv
// Handshake bundle between sweep_seq and its DAC writer, ADC reader and UART transmitter.
interface sweep_seq_if #(
   parameter int DAC_W = 12,
   parameter int ADC_W = 12
);
   logic             dac_start_o;
   logic [DAC_W-1:0] dac_data_o;
   logic             dac_eos_i;
   logic             adc_start_o;
   logic [ADC_W-1:0] adc_data_i;
   logic             adc_eos_i;
   logic             tx_start_o;
   logic [7:0]       tx_data_o;
   logic             tx_done_i;

   modport master (
      output dac_start_o, dac_data_o, adc_start_o, tx_start_o, tx_data_o,
      input  dac_eos_i, adc_data_i, adc_eos_i, tx_done_i
   );

   modport slave (
      input  dac_start_o, dac_data_o, adc_start_o, tx_start_o, tx_data_o,
      output dac_eos_i, adc_data_i, adc_eos_i, tx_done_i
   );
endinterface

// File: rtl/sweep_seq.sv
// sweep_seq: steps a DAC code across [min,max], settles, samples the ADC and streams each sample as UART bytes.
// Define SWEEP_CODE_ECHO_EN to prefix every sample with the two-byte DAC code it was taken at.
module sweep_seq #(
   parameter int DAC_W         = 12,
   parameter int ADC_W         = 12,
   parameter int SETTLE_CYCLES = 1000,
   parameter int CNT_W         = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [DAC_W-1:0] code_min_i,
   input  logic [DAC_W-1:0] code_max_i,
   input  logic [DAC_W-1:0] step_i,
   sweep_seq_if.master      bus,
   output logic             busy_o,
   output logic             eos_o,
   output logic             aborted_o,
   output logic [CNT_W-1:0] point_cnt_o
);

   typedef enum logic [3:0] {
      IDLE, DAC_WR, DAC_WAIT, SETTLE, ADC_RD, ADC_WAIT,
`ifdef SWEEP_CODE_ECHO_EN
      TX_CH, TX_CH_WAIT, TX_CL, TX_CL_WAIT,
`endif
      TX_HI, TX_HI_WAIT, TX_LO, TX_LO_WAIT, NEXT, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [DAC_W-1:0] code_q, code_d;
   logic [DAC_W-1:0] max_q, max_d;
   logic [DAC_W-1:0] step_q, step_d;
   logic [CNT_W-1:0] settle_q, settle_d;
   logic [CNT_W-1:0] pts_q, pts_d;
   logic [ADC_W-1:0] sample_q, sample_d;
   logic             abort_q, abort_d;
   logic             aborted_q, aborted_d;

   logic             abort_pend;
   logic [DAC_W:0]   next_code;
   logic [15:0]      sample_ext;

   // An abort arriving this cycle counts as much as one recorded earlier.
   assign abort_pend = abort_q | abort_i;
   assign next_code  = {1'b0, code_q} + {1'b0, step_q};
   assign sample_ext = 16'(sample_q);

`ifdef SWEEP_CODE_ECHO_EN
   logic [15:0] code_ext;
   assign code_ext = 16'(code_q);
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:       if (start_i) state_d = (code_min_i > code_max_i) ? DONE : DAC_WR;
         DAC_WR:     state_d = DAC_WAIT;
         DAC_WAIT:   if (bus.dac_eos_i) state_d = abort_pend ? DONE : SETTLE;
         SETTLE:     if (abort_pend) state_d = DONE;
                     else if (settle_q == '0) state_d = ADC_RD;
         ADC_RD:     state_d = ADC_WAIT;
`ifdef SWEEP_CODE_ECHO_EN
         ADC_WAIT:   if (bus.adc_eos_i) state_d = abort_pend ? DONE : TX_CH;
         TX_CH:      state_d = TX_CH_WAIT;
         TX_CH_WAIT: if (bus.tx_done_i) state_d = abort_pend ? DONE : TX_CL;
         TX_CL:      state_d = TX_CL_WAIT;
         TX_CL_WAIT: if (bus.tx_done_i) state_d = abort_pend ? DONE : TX_HI;
`else
         ADC_WAIT:   if (bus.adc_eos_i) state_d = abort_pend ? DONE : TX_HI;
`endif
         TX_HI:      state_d = TX_HI_WAIT;
         TX_HI_WAIT: if (bus.tx_done_i) state_d = abort_pend ? DONE : TX_LO;
         TX_LO:      state_d = TX_LO_WAIT;
         // A fully sent point is always counted; NEXT decides whether to stop.
         TX_LO_WAIT: if (bus.tx_done_i) state_d = NEXT;
         NEXT:       state_d = (abort_pend || next_code > {1'b0, max_q}) ? DONE : DAC_WR;
         DONE:       state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      code_d    = code_q;
      max_d     = max_q;
      step_d    = step_q;
      settle_d  = settle_q;
      pts_d     = pts_q;
      sample_d  = sample_q;
      abort_d   = (state_q == IDLE) ? 1'b0 : abort_pend;
      aborted_d = aborted_q;
      unique case (state_q)
         IDLE: if (start_i) begin
            code_d    = code_min_i;
            max_d     = code_max_i;
            step_d    = (step_i == '0) ? DAC_W'(1) : step_i;
            pts_d     = '0;
            aborted_d = 1'b0;
         end
         DAC_WAIT: settle_d = CNT_W'(SETTLE_CYCLES - 1);
         SETTLE:   if (settle_q != '0) settle_d = settle_q - 1'b1;
         ADC_WAIT: if (bus.adc_eos_i) sample_d = bus.adc_data_i;
         NEXT: begin
            if (pts_q != '1) pts_d = pts_q + 1'b1;
            if (state_d == DAC_WR) code_d = next_code[DAC_W-1:0];
         end
         default: ;
      endcase
      if (state_d == DONE && state_q != DONE && state_q != IDLE && abort_pend) aborted_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         code_q    <= '0;
         max_q     <= '0;
         step_q    <= '0;
         settle_q  <= '0;
         pts_q     <= '0;
         sample_q  <= '0;
         abort_q   <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         code_q    <= code_d;
         max_q     <= max_d;
         step_q    <= step_d;
         settle_q  <= settle_d;
         pts_q     <= pts_d;
         sample_q  <= sample_d;
         abort_q   <= abort_d;
         aborted_q <= aborted_d;
      end
   end

   always_comb begin
      bus.dac_start_o = (state_q == DAC_WR);
      bus.adc_start_o = (state_q == ADC_RD);
      bus.tx_start_o  = (state_q == TX_HI) || (state_q == TX_LO);
      bus.tx_data_o   = 8'h00;
      busy_o          = (state_q != IDLE) && (state_q != DONE);
      eos_o           = (state_q == DONE);
      unique case (state_q)
         TX_HI, TX_HI_WAIT: bus.tx_data_o = sample_ext[15:8];
         TX_LO, TX_LO_WAIT: bus.tx_data_o = sample_ext[7:0];
`ifdef SWEEP_CODE_ECHO_EN
         TX_CH, TX_CH_WAIT: bus.tx_data_o = code_ext[15:8];
         TX_CL, TX_CL_WAIT: bus.tx_data_o = code_ext[7:0];
`endif
         default: ;
      endcase
`ifdef SWEEP_CODE_ECHO_EN
      if (state_q == TX_CH || state_q == TX_CL) bus.tx_start_o = 1'b1;
`endif
   end

   assign bus.dac_data_o = code_q;
   assign aborted_o      = aborted_q;
   assign point_cnt_o    = pts_q;

endmodule

// File: tb/tb_sweep_seq.sv
// Bench for sweep_seq: latency-randomised DAC/ADC/UART responders and a queue-based sweep model.
module tb_sweep_seq;
   localparam int DAC_W  = 12;
   localparam int ADC_W  = 12;
   localparam int SETTLE = 4;
   localparam int CNT_W  = 16;
   localparam int OW     = 3 + CNT_W + 1 + DAC_W + 1 + 1 + 8;
`ifdef SWEEP_CODE_ECHO_EN
   localparam int BPP = 4;
`else
   localparam int BPP = 2;
`endif

   typedef int q_t[$];

   logic             clk, rst_n, start, abort;
   logic [DAC_W-1:0] cmin, cmax, cstep;
   logic             busy, eos, aborted;
   logic [CNT_W-1:0] pcnt;

   sweep_seq_if #(.DAC_W(DAC_W), .ADC_W(ADC_W)) bus ();

   sweep_seq #(.DAC_W(DAC_W), .ADC_W(ADC_W), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .abort_i(abort),
      .code_min_i(cmin), .code_max_i(cmax), .step_i(cstep), .bus(bus),
      .busy_o(busy), .eos_o(eos), .aborted_o(aborted), .point_cnt_o(pcnt)
   );

   int tests = 0, fails = 0, cyc = 0;
   q_t dac_log, tx_log, adc_log, settle_log;
   int eos_cnt = 0, eos_cyc = 0, start_cyc = 0;
   int dac_start_cnt = 0, adc_start_cnt = 0, dac_eos_cnt = 0, dac_eos_cyc = 0, tx_hold_err = 0;
   int lat_fix = 3, fixed_adc = -1;
   int dac_cd = -1, adc_cd = -1, tx_cd = -1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: reached cycle %0d, limit 90000", cyc);
      $fatal(1, "watchdog");
   end

   function automatic int lat();
      return (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 5));
   endfunction

   function automatic int first_diff(input q_t a, input q_t b);
      if (a.size() != b.size()) return -2;
      foreach (a[i]) if (a[i] != b[i]) return i;
      return -1;
   endfunction

   task automatic model_codes(input int mn, input int mx, input int st, output q_t q);
      int s;
      q = {};
      s = (st == 0) ? 1 : st;
      for (int c = mn; c <= mx; c += s) q.push_back(c);
   endtask

   task automatic model_bytes(input q_t codes, input q_t smp, output q_t b);
      b = {};
      for (int i = 0; i < smp.size(); i++) begin
`ifdef SWEEP_CODE_ECHO_EN
         if (i < codes.size()) begin
            b.push_back((codes[i] >> 8) & 255);
            b.push_back(codes[i] & 255);
         end
`endif
         b.push_back((smp[i] >> 8) & 255);
         b.push_back(smp[i] & 255);
      end
   endtask

   // Peripheral responders and event monitor, all acting on the falling edge.
   initial begin
      int v;
      bus.dac_eos_i = 1'b0; bus.adc_eos_i = 1'b0; bus.tx_done_i = 1'b0; bus.adc_data_i = '0;
      forever begin
         @(negedge clk);
         if (eos) begin eos_cnt++; eos_cyc = cyc; end
         if (bus.adc_start_o) begin adc_start_cnt++; settle_log.push_back(cyc - dac_eos_cyc); end
         bus.dac_eos_i = 1'b0; bus.adc_eos_i = 1'b0; bus.tx_done_i = 1'b0;
         bus.adc_data_i = ADC_W'($urandom);
         if (!rst_n) begin
            dac_cd = -1; adc_cd = -1; tx_cd = -1;
         end else begin
            if (dac_cd > 0) begin
               dac_cd--;
               if (dac_cd == 0) begin bus.dac_eos_i = 1'b1; dac_eos_cnt++; dac_eos_cyc = cyc; end
            end
            if (adc_cd > 0) begin
               adc_cd--;
               if (adc_cd == 0) begin
                  v = (fixed_adc >= 0) ? fixed_adc : int'($urandom_range(0, 4095));
                  bus.adc_eos_i = 1'b1; bus.adc_data_i = ADC_W'(v); adc_log.push_back(v);
               end
            end
            if (tx_cd > 0) begin
               tx_cd--;
               if (tx_cd == 0) begin
                  bus.tx_done_i = 1'b1;
                  if (int'(bus.tx_data_o) != tx_log[$]) tx_hold_err++;
               end
            end
            if (bus.dac_start_o) begin dac_log.push_back(int'(bus.dac_data_o)); dac_start_cnt++; dac_cd = lat(); end
            if (bus.adc_start_o) adc_cd = lat();
            if (bus.tx_start_o) begin tx_log.push_back(int'(bus.tx_data_o)); tx_cd = lat(); end
         end
      end
   end

   task automatic clear_logs();
      dac_log.delete(); tx_log.delete(); adc_log.delete(); settle_log.delete();
      eos_cnt = 0; dac_start_cnt = 0; adc_start_cnt = 0; dac_eos_cnt = 0; tx_hold_err = 0;
   endtask

   task automatic do_sweep(input int mn, input int mx, input int st, output bit to);
      clear_logs();
      @(negedge clk);
      cmin = DAC_W'(mn); cmax = DAC_W'(mx); cstep = DAC_W'(st);
      start = 1'b1; start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      cmin = DAC_W'($urandom); cmax = DAC_W'($urandom); cstep = DAC_W'($urandom);
      to = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         if (eos_cnt != 0) begin to = 1'b0; break; end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [OW-1:0] o;
      repeat (3) @(negedge clk);
      o = {busy, eos, aborted, pcnt, bus.dac_start_o, bus.dac_data_o, bus.adc_start_o, bus.tx_start_o, bus.tx_data_o};
      tests++; if (o !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", o); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      o = {busy, eos, aborted, pcnt, bus.dac_start_o, bus.dac_data_o, bus.adc_start_o, bus.tx_start_o, bus.tx_data_o};
      tests++; if (o !== '0) begin fails++; $display("FAIL idle_outputs: got %h want 0", o); end
   endtask

   task automatic test_basic();
      bit to; q_t ec, eb; int d, bad;
      lat_fix = 3; fixed_adc = 12'hABC;
      do_sweep(12'h100, 12'h102, 1, to);
      model_codes(12'h100, 12'h102, 1, ec);
      model_bytes(ec, adc_log, eb);
      tests++; if (to) begin fails++; $display("FAIL basic_timeout: eos not seen"); end
      d = first_diff(dac_log, ec);
      tests++; if (d != -1) begin fails++; $display("FAIL basic_codes: diff at %0d, got %0d codes want %0d", d, dac_log.size(), ec.size()); end
      d = first_diff(tx_log, eb);
      tests++; if (d != -1 || eb.size() != 3 * BPP) begin fails++; $display("FAIL basic_bytes: diff at %0d, got %0d bytes want %0d", d, tx_log.size(), 3 * BPP); end
      tests++; if (pcnt !== 16'd3) begin fails++; $display("FAIL basic_pcnt: got %0d want 3", pcnt); end
      tests++; if (aborted !== 1'b0 || eos_cnt != 1) begin fails++; $display("FAIL basic_end: aborted %0b eos %0d want 0 1", aborted, eos_cnt); end
      tests++; if (tx_hold_err != 0) begin fails++; $display("FAIL basic_tx_hold: got %0d changes want 0", tx_hold_err); end
      bad = 0;
      foreach (settle_log[i]) if (settle_log[i] != SETTLE + 1) bad++;
      tests++; if (bad != 0 || settle_log.size() != 3) begin fails++; $display("FAIL settle_time: got %0d wrong of %0d, want %0d cycles each", bad, settle_log.size(), SETTLE + 1); end
   endtask

   task automatic test_overflow();
      bit to; q_t ec;
      lat_fix = 2; fixed_adc = -1;
      do_sweep(12'hFFE, 12'hFFF, 4, to);
      model_codes(12'hFFE, 12'hFFF, 4, ec);
      tests++; if (to || first_diff(dac_log, ec) != -1) begin fails++; $display("FAIL ovf_codes: got %0d codes want %0d (timeout %0b)", dac_log.size(), ec.size(), to); end
      tests++; if (pcnt !== 16'd1) begin fails++; $display("FAIL ovf_pcnt: got %0d want 1", pcnt); end
   endtask

   task automatic test_empty();
      bit to;
      do_sweep(12'h010, 12'h00F, 1, to);
      tests++; if (to || dac_start_cnt != 0) begin fails++; $display("FAIL empty_dac: got %0d dac starts want 0 (timeout %0b)", dac_start_cnt, to); end
      tests++; if (eos_cyc - start_cyc < 1 || eos_cyc - start_cyc > 2) begin fails++; $display("FAIL empty_eos: got %0d cycles want 1..2", eos_cyc - start_cyc); end
      tests++; if (pcnt !== 16'd0 || busy !== 1'b0) begin fails++; $display("FAIL empty_pcnt: got %0d busy %0b want 0 0", pcnt, busy); end
   endtask

   task automatic test_abort_settle();
      bit to; int ac, n;
      lat_fix = 3; fixed_adc = -1; dac_eos_cnt = 0; ac = 0; n = 0;
      fork
         do_sweep(12'h020, 12'h030, 2, to);
         begin
            while (dac_eos_cnt < 2 && n < 3000) begin @(posedge clk); n++; end
            @(negedge clk); abort = 1'b1; ac = cyc;
            @(negedge clk); abort = 1'b0;
         end
      join
      tests++; if (to || eos_cyc - ac != 1) begin fails++; $display("FAIL abort_eos: got %0d cycles after abort want 1 (timeout %0b)", eos_cyc - ac, to); end
      tests++; if (adc_start_cnt != 1 || dac_start_cnt != 2) begin fails++; $display("FAIL abort_starts: got adc %0d dac %0d want 1 2", adc_start_cnt, dac_start_cnt); end
      tests++; if (aborted !== 1'b1) begin fails++; $display("FAIL abort_flag: got %0b want 1", aborted); end
      tests++; if (pcnt !== 16'd1 || tx_log.size() != BPP) begin fails++; $display("FAIL abort_pcnt: got %0d bytes %0d want 1 %0d", pcnt, tx_log.size(), BPP); end
   endtask

   task automatic test_random();
      bit to; q_t ec, eb; int mn, mx, st, d;
      lat_fix = 0; fixed_adc = -1;
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      for (int it = 0; it < 6; it++) begin
         mn = int'($urandom_range(0, 4095));
         mx = mn + int'($urandom_range(0, 60));
         if (mx > 4095) mx = 4095;
         if (it == 5 && mn > 0) mx = mn - 1;
         st = (it == 0) ? 0 : int'($urandom_range(1, 40));
         do_sweep(mn, mx, st, to);
         model_codes(mn, mx, st, ec);
         model_bytes(ec, adc_log, eb);
         tests++; if (to) begin fails++; $display("FAIL rand%0d_timeout: eos not seen", it); end
         d = first_diff(dac_log, ec);
         tests++; if (d != -1) begin fails++; $display("FAIL rand%0d_codes: diff at %0d, got %0d want %0d codes", it, d, dac_log.size(), ec.size()); end
         d = first_diff(tx_log, eb);
         tests++; if (d != -1 || tx_log.size() != ec.size() * BPP) begin fails++; $display("FAIL rand%0d_bytes: diff at %0d, got %0d want %0d bytes", it, d, tx_log.size(), ec.size() * BPP); end
         tests++; if (int'(pcnt) != ec.size() || aborted !== 1'b0) begin fails++; $display("FAIL rand%0d_status: got pcnt %0d aborted %0b want %0d 0", it, pcnt, aborted, ec.size()); end
         tests++; if (tx_hold_err != 0) begin fails++; $display("FAIL rand%0d_tx_hold: got %0d want 0", it, tx_hold_err); end
      end
   endtask

   task automatic test_back_to_back();
      bit to; q_t ec;
      lat_fix = 2; fixed_adc = -1;
      fork
         do_sweep(12'h040, 12'h048, 2, to);
         begin
            repeat (12) @(negedge clk);
            start = 1'b1; cmin = '0; cmax = 12'hFFF; cstep = 12'd1;
            @(negedge clk); start = 1'b0;
         end
      join
      model_codes(12'h040, 12'h048, 2, ec);
      tests++; if (to || first_diff(dac_log, ec) != -1) begin fails++; $display("FAIL restart_codes: got %0d codes want %0d (timeout %0b)", dac_log.size(), ec.size(), to); end
      tests++; if (eos_cnt != 1 || pcnt !== 16'd5) begin fails++; $display("FAIL restart_end: got eos %0d pcnt %0d want 1 5", eos_cnt, pcnt); end
      do_sweep(12'h7F0, 12'h7F3, 3, to);
      model_codes(12'h7F0, 12'h7F3, 3, ec);
      tests++; if (to || first_diff(dac_log, ec) != -1 || pcnt !== 16'd2) begin fails++; $display("FAIL b2b_sweep: got %0d codes pcnt %0d want 2 2", dac_log.size(), pcnt); end
   endtask

   task automatic test_reset_mid();
      bit to; q_t ec; int n; logic [OW-1:0] o;
      lat_fix = 3; fixed_adc = -1; n = 0;
      clear_logs();
      @(negedge clk);
      cmin = 12'h200; cmax = 12'h205; cstep = 12'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (tx_log.size() < BPP && n < 2000) begin @(posedge clk); n++; end
      #2 rst_n = 1'b0;
      #1;
      o = {busy, eos, aborted, pcnt, bus.dac_start_o, bus.dac_data_o, bus.adc_start_o, bus.tx_start_o, bus.tx_data_o};
      tests++; if (o !== '0 || n >= 2000) begin fails++; $display("FAIL midreset_outputs: got %h want 0 (waited %0d)", o, n); end
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (busy !== 1'b0 || pcnt !== '0) begin fails++; $display("FAIL midreset_idle: got busy %0b pcnt %0d want 0 0", busy, pcnt); end
      do_sweep(12'h010, 12'h011, 1, to);
      model_codes(12'h010, 12'h011, 1, ec);
      tests++; if (to || first_diff(dac_log, ec) != -1 || pcnt !== 16'd2) begin fails++; $display("FAIL midreset_recover: got %0d codes pcnt %0d want 2 2", dac_log.size(), pcnt); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      cmin = '0; cmax = '0; cstep = '0;
      test_reset();
      test_basic();
      test_overflow();
      test_empty();
      test_abort_settle();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
